sample_accum_avg: RTL and testbench
===================================

SAMPLE_ACCUM_AVG -- requirements
Module: sample_accum_avg

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 12, giving the sample and average width in bits.
REQ-002 The block SHALL have a parameter LOG2_N, default 4, fixing the window length N = 2^LOG2_N samples (legal range 1..8).
REQ-003 The block SHALL have input clk, 1 bit: the single clock domain; all logic is on its rising edge.
REQ-004 The block SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have input en, 1 bit: averaging enable; low aborts and holds the block idle.
REQ-006 The block SHALL have input tick, 1 bit: one-cycle sample strobe from the upstream clock divider.
REQ-007 The block SHALL have input sample, DATA_W bits: unsigned sample, captured only in cycles where tick is high.
REQ-008 The block SHALL have output avg, DATA_W bits: rounded mean of the last completed window.
REQ-009 The block SHALL have output avg_valid, 1 bit: one-cycle pulse marking a new avg.
REQ-010 The block SHALL have output fill, LOG2_N+1 bits: number of samples in the current partial window.

Function
REQ-011 States SHALL be IDLE and ACCUM; the block enters ACCUM when en is high, and any state goes to IDLE when en is low.
REQ-012 In IDLE the block SHALL hold the accumulator and fill at 0 and SHALL ignore tick; avg SHALL hold its last value.
REQ-013 In ACCUM, each cycle with tick high SHALL add sample (zero-extended) to an accumulator of DATA_W+LOG2_N bits and increment fill.
REQ-014 The accumulator SHALL never overflow: N samples of full-scale value fit exactly in DATA_W+LOG2_N bits.
REQ-015 On the tick that supplies the Nth sample, the block SHALL compute (sum + 2^(LOG2_N-1)) >> LOG2_N with a DATA_W+LOG2_N+1-bit intermediate, giving round-half-up.
REQ-016 The rounded result SHALL never exceed 2^DATA_W-1, so no saturation logic is required.
REQ-017 avg and avg_valid SHALL be registered; the Nth tick at cycle t SHALL produce avg_valid high in cycle t+1 only (latency 1).
REQ-018 On the completing tick, the accumulator and fill SHALL restart at 0 in the same edge, so windows are back-to-back with no lost tick.
REQ-019 A tick in cycle t+1, while avg_valid is high, SHALL be counted as sample 1 of the next window.
REQ-020 fill SHALL read 0..N-1 and SHALL never present N.
REQ-021 Ticks on consecutive cycles (upstream interval 0) SHALL each be accepted.
REQ-022 If en is low in the same cycle as a tick, the tick SHALL be discarded: the partial window is dropped and no avg_valid is produced.
REQ-023 A completed window whose avg_valid is pending SHALL still emit in the next cycle even if en falls.

Reset
REQ-024 While rst is high, the block SHALL set the state to IDLE, the accumulator to 0, fill to 0, avg to 0 and avg_valid to 0.
REQ-025 rst SHALL take priority over en and tick; a partial window at reset SHALL be discarded and SHALL produce no output.
REQ-026 After rst is released, the first window SHALL begin with the first tick accepted in ACCUM.

Structure
REQ-027 The shared accum_avg package SHALL hold the default DATA_W/LOG2_N constants and the state enum (IDLE, ACCUM).
REQ-028 The block SHALL contain no sub-module.
REQ-029 The natural grouping is the accum_avg top-level, which instantiates the clock divider driving tick plus this block; that top-level is outside this spec.

Verification (DATA_W=12, LOG2_N=2, N=4)
REQ-030 en=1, ticks with samples 10,20,30,41 -> one cycle after the 4th tick, avg=25 (101+2>>2) and avg_valid high for exactly one cycle.
REQ-031 Four ticks of sample 4095 -> avg=4095, with no wrap; samples 1,1,1,3 -> avg=2 (rounding: 6+2>>2).
REQ-032 Ticks every cycle for 8 cycles with samples 0..7 -> avg=2 then avg=6 (rounded from 1.5 and 5.5), with avg_valid pulses exactly 4 cycles apart.
REQ-033 Two ticks, then en low for 1 cycle, then en high and four ticks of 100 -> exactly one avg_valid, with avg=100.
REQ-034 rst asserted after 3 ticks, then four ticks of 8 -> avg=0 during rst, then a single avg=8; fill sequence 0,1,2,3,0.

Source files
------------

// File: rtl/accum_avg_pkg.sv
// Shared definitions for the accum_avg slice: default widths and the
// averaging state encoding.
package accum_avg_pkg;

    localparam int unsigned DEFAULT_DATA_W = 12;
    localparam int unsigned DEFAULT_LOG2_N = 4;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

endpackage

// File: rtl/sample_accum_avg.sv
// Windowed sample averager: sums N = 2^LOG2_N ticked samples and emits the
// round-half-up mean of each completed window as a one-cycle pulse.
module sample_accum_avg
    import accum_avg_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned LOG2_N = DEFAULT_LOG2_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tick,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg,
    output logic              avg_valid,
    output logic [LOG2_N:0]   fill
);

    localparam int unsigned SUM_W  = DATA_W + LOG2_N;
    localparam int unsigned RND_W  = SUM_W + 1;
    localparam int unsigned FILL_W = LOG2_N + 1;
    localparam logic [FILL_W-1:0] LAST = FILL_W'((1 << LOG2_N) - 1);
    localparam logic [RND_W-1:0]  HALF = RND_W'(1) << (LOG2_N - 1);

    state_t           state, state_next;
    logic             accept, last;
    logic [SUM_W-1:0] acc, sum_next;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        accept     = 1'b0;
        last       = 1'b0;
        sum_next   = acc + SUM_W'(sample);
        if (en) state_next = ACCUM;
        // A tick is taken only when already accumulating and still enabled.
        if (state == ACCUM && en && tick) accept = 1'b1;
        if (fill == LAST) last = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            fill      <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= accept && last;
            if (accept && last) begin
                // Completing tick restarts the window on the same edge.
                avg  <= DATA_W'((RND_W'(sum_next) + HALF) >> LOG2_N);
                acc  <= '0;
                fill <= '0;
            end else if (accept) begin
                acc  <= sum_next;
                fill <= fill + 1'b1;
            end else if (state != ACCUM || !en) begin
                acc  <= '0;
                fill <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sample_accum_avg.sv
// Directed self-checking bench for sample_accum_avg with DATA_W=12, LOG2_N=2.
module tb_sample_accum_avg;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tick;
    logic [11:0] sample;
    logic [11:0] avg;
    logic        avg_valid;
    logic [2:0]  fill;

    int checks = 0;
    int errors = 0;

    sample_accum_avg #(.DATA_W(12), .LOG2_N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .tick      (tick),
        .sample    (sample),
        .avg       (avg),
        .avg_valid (avg_valid),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus on the falling edge, settle past the rising edge.
    task automatic step(input logic t, input logic [11:0] s);
        @(negedge clk);
        tick   = t;
        sample = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; tick = 1'b0; sample = '0;
        step(1'b1, 12'd5);
        step(1'b1, 12'd5);
        checks++; if (avg !== 12'd0) begin errors++; $display("FAIL reset_avg got %0d want 0", avg); end
        checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", avg_valid); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill); end
        rst = 1'b0;
        step(1'b0, 12'd0);
    endtask

    task automatic test_basic;
        logic [11:0] s [4];
        s[0] = 12'd10; s[1] = 12'd20; s[2] = 12'd30; s[3] = 12'd41;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, s[i]);
            checks++;
            if (fill !== 3'(i + 1)) begin errors++; $display("FAIL basic_fill%0d got %0d want %0d", i, fill, i + 1); end
        end
        step(1'b1, s[3]);
        checks++; if (avg_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", avg_valid); end
        checks++; if (avg !== 12'd25) begin errors++; $display("FAIL basic_avg got %0d want 25", avg); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL basic_fill_wrap got %0d want 0", fill); end
        step(1'b0, 12'd0);
        checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_len got %b want 0", avg_valid); end
        checks++; if (avg !== 12'd25) begin errors++; $display("FAIL basic_hold got %0d want 25", avg); end
    endtask

    task automatic test_full_scale;
        for (int i = 0; i < 4; i++) step(1'b1, 12'd4095);
        checks++; if (avg_valid !== 1'b1 || avg !== 12'd4095) begin
            errors++; $display("FAIL full_scale got %0d/%b want 4095/1", avg, avg_valid); end
        step(1'b0, 12'd0);
        step(1'b1, 12'd1);
        step(1'b1, 12'd1);
        step(1'b1, 12'd1);
        step(1'b1, 12'd3);
        checks++; if (avg_valid !== 1'b1 || avg !== 12'd2) begin
            errors++; $display("FAIL round_up got %0d/%b want 2/1", avg, avg_valid); end
        step(1'b0, 12'd0);
    endtask

    task automatic test_back_to_back;
        int first, second, pulses;
        first = -1; second = -1; pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 12'(i));
            checks++;
            if (avg_valid !== ((i == 3) || (i == 7))) begin
                errors++; $display("FAIL b2b_valid%0d got %b want %b", i, avg_valid, (i == 3) || (i == 7));
            end
            if (avg_valid === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    checks++; if (avg !== 12'd2) begin errors++; $display("FAIL b2b_avg1 got %0d want 2", avg); end
                end else begin
                    second = i;
                    checks++; if (avg !== 12'd6) begin errors++; $display("FAIL b2b_avg2 got %0d want 6", avg); end
                end
            end
        end
        checks++; if (pulses !== 2 || second - first !== 4) begin
            errors++; $display("FAIL b2b_spacing got %0d pulses gap %0d want 2 gap 4", pulses, second - first); end
        step(1'b0, 12'd0);
    endtask

    task automatic test_en_abort;
        int pulses;
        logic [11:0] last_avg;
        pulses = 0; last_avg = 12'd0;
        step(1'b1, 12'd50);
        step(1'b1, 12'd50);
        en = 1'b0;
        step(1'b1, 12'd50);
        checks++; if (fill !== 3'd0 || avg_valid !== 1'b0) begin
            errors++; $display("FAIL abort_drop got fill %0d valid %b want 0/0", fill, avg_valid); end
        en = 1'b1;
        step(1'b0, 12'd0);
        for (int i = 0; i < 6; i++) begin
            step(i < 4, 12'd100);
            if (avg_valid === 1'b1) begin pulses++; last_avg = avg; end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL abort_pulses got %0d want 1", pulses); end
        checks++; if (last_avg !== 12'd100) begin errors++; $display("FAIL abort_avg got %0d want 100", last_avg); end
    endtask

    task automatic test_rst_midwindow;
        logic [2:0] exp_fill [5];
        exp_fill[0] = 3'd0; exp_fill[1] = 3'd1; exp_fill[2] = 3'd2; exp_fill[3] = 3'd3; exp_fill[4] = 3'd0;
        for (int i = 0; i < 3; i++) step(1'b1, 12'd8);
        rst = 1'b1;
        step(1'b1, 12'd8);
        checks++; if (avg !== 12'd0 || avg_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid got %0d/%b want 0/0", avg, avg_valid); end
        rst = 1'b0;
        step(1'b0, 12'd0);
        checks++; if (fill !== exp_fill[0]) begin errors++; $display("FAIL rst_fill0 got %0d want 0", fill); end
        for (int i = 1; i < 5; i++) begin
            step(1'b1, 12'd8);
            checks++;
            if (fill !== exp_fill[i]) begin errors++; $display("FAIL rst_fill%0d got %0d want %0d", i, fill, exp_fill[i]); end
        end
        checks++; if (avg_valid !== 1'b1 || avg !== 12'd8) begin
            errors++; $display("FAIL rst_avg got %0d/%b want 8/1", avg, avg_valid); end
        en = 1'b0;
        step(1'b0, 12'd0);
        checks++; if (avg_valid !== 1'b0 || avg !== 12'd8) begin
            errors++; $display("FAIL idle_hold got %0d/%b want 8/0", avg, avg_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_back_to_back();
        test_en_abort();
        test_rst_midwindow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
